int_trigger_ctrl: RTL

- Memory-mapped external-interrupt scheduler for the MIPS P7 system; drives the CPU `interrupt` input.
- Watches the macroscopic PC, raises `interrupt` when the PC hits a programmed target, and holds it until software acknowledges with a store to the ACK word.
- Supports one-shot, repeat, delayed and count-limited triggering, so interrupt scenarios are scheduled by programs rather than hard-coded.

---
 rtl/int_trigger_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/int_trigger_ctrl.sv
// Memory-mapped PC-match interrupt scheduler: arms on a target PC, raises interrupt until ACK.
// Latency: interrupt rises one cycle after ASSERT is entered (DELAY adds DELAY cycles), falls one cycle after it is left.
// Backpressure: none; bus writes complete in one cycle and reads are combinational.
module int_trigger_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h00007f20,
    parameter int          CNT_W     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] macroscopic_pc,
    input  logic [31:0] m_int_addr,
    input  logic [31:0] m_int_wdata,
    input  logic [3:0]  m_int_byteen,
    output logic [31:0] m_int_rdata,
    output logic        interrupt
);

    localparam logic [31:0] ACK_ADDR  = BASE_ADDR;
    localparam logic [31:0] TGT_ADDR  = BASE_ADDR + 32'd4;
    localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd8;
    localparam logic [31:0] CNT_ADDR  = BASE_ADDR + 32'd12;

    // Encoding is software-visible through STATUS[2:0].
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ASSERT = 3'd3,
        ST_REARM  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        target_q, target_d;
    logic [15:0]        ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   dcnt_q, dcnt_d;
    logic               interrupt_q, interrupt_d;

    logic [31:0]        addr_w;
    logic [31:0]        wmask;
    logic [15:0]        ctrl_wr_val;
    logic               wr_en, ack_wr, tgt_wr, ctrl_wr, pc_match;
    logic [CNT_W:0]     cnt_inc;
    logic [CNT_W:0]     maxcnt_ext;
    logic [CNT_W-1:0]   delay_ext;

    // Bus decode, byte-merged register write values and PC match.
    always_comb begin
        addr_w      = m_int_addr & ~32'd3;
        wr_en       = |m_int_byteen;
        ack_wr      = wr_en && (addr_w == ACK_ADDR);
        tgt_wr      = wr_en && (addr_w == TGT_ADDR);
        ctrl_wr     = wr_en && (addr_w == CTRL_ADDR);
        wmask       = {{8{m_int_byteen[3]}}, {8{m_int_byteen[2]}},
                       {8{m_int_byteen[1]}}, {8{m_int_byteen[0]}}};
        ctrl_wr_val = (ctrl_q & ~wmask[15:0]) | (m_int_wdata[15:0] & wmask[15:0]);
        target_d    = target_q;
        if (tgt_wr) begin
            target_d = ((target_q & ~wmask) | (m_int_wdata & wmask)) & ~32'd3;
        end
        ctrl_d      = ctrl_wr ? ctrl_wr_val : ctrl_q;
        pc_match    = (macroscopic_pc & ~32'd3) == target_q;
        cnt_inc     = {1'b0, count_q} + (CNT_W+1)'(1);
        maxcnt_ext  = {{(CNT_W-3){1'b0}}, ctrl_q[7:4]};
        delay_ext   = CNT_W'(ctrl_q[15:8]);
    end

    // Trigger FSM next state; a CTRL write restarts the scheduler and wins over everything else.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        dcnt_d      = dcnt_q;
        if (ctrl_wr) begin
            count_d = '0;
            state_d = ctrl_wr_val[0] ? ST_ARMED : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_ARMED: begin
                    if (pc_match) begin
                        if (delay_ext != '0) begin
                            state_d = ST_WAIT;
                            dcnt_d  = delay_ext - CNT_W'(1);
                        end else begin
                            state_d = ST_ASSERT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dcnt_q == '0) begin
                        state_d = ST_ASSERT;
                    end else begin
                        dcnt_d  = dcnt_q - CNT_W'(1);
                    end
                end
                ST_ASSERT: begin
                    if (ack_wr) begin
                        count_d = (count_q == '1) ? count_q : cnt_inc[CNT_W-1:0];
                        if (ctrl_q[1] && ((ctrl_q[7:4] == 4'd0) || (cnt_inc < maxcnt_ext))) begin
                            state_d = ST_REARM;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                // Hold off until the PC moves away so a stalled PC cannot retrigger.
                ST_REARM: if (!pc_match) state_d = ST_ARMED;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
        interrupt_d = (state_q == ST_ASSERT);
    end

    // Register state; async reset returns everything to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            ctrl_q      <= '0;
            count_q     <= '0;
            dcnt_q      <= '0;
            interrupt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            ctrl_q      <= ctrl_d;
            count_q     <= count_d;
            dcnt_q      <= dcnt_d;
            interrupt_q <= interrupt_d;
        end
    end

    // Combinational read mux; unmapped addresses read zero.
    always_comb begin
        m_int_rdata = 32'd0;
        if (addr_w == ACK_ADDR) begin
            m_int_rdata = {24'd0, count_q[3:0], 1'b0, state_q};
        end else if (addr_w == TGT_ADDR) begin
            m_int_rdata = target_q;
        end else if (addr_w == CTRL_ADDR) begin
            m_int_rdata = {16'd0, ctrl_q};
        end else if (addr_w == CNT_ADDR) begin
            m_int_rdata = {{(32-CNT_W){1'b0}}, count_q};
        end
    end

    assign interrupt = interrupt_q;

endmodule
